// File: rtl/mem_stage.sv
// Memory pipeline stage: forwards ALU results, issues aligned loads/stores
// on a request/ack data bus, and reports misaligned or timed-out accesses.
module mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_flush,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_rs2,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [1:0]  ex_size,
  input  logic        ex_sign,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic [31:0] wb_data,
  output logic        mem_err
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  // Last WAIT cycle index before the access is declared timed out
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [1:0]  r_off;
  logic [1:0]  r_size;
  logic        r_sign;
  logic        r_reg_write;
  logic [4:0]  r_rd;

  logic        accept;
  logic        is_mem;
  logic        misaligned;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] ld_shifted;
  logic [31:0] ld_data;

  assign ex_ready = (state == IDLE);

  // Acceptance and alignment decode of the presented instruction
  always_comb begin
    accept = ex_valid && ex_ready && !ex_flush;
    is_mem = ex_mem_read || ex_mem_write;
    case (ex_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = ex_alu_result[0];
      2'b10:   misaligned = (ex_alu_result[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Lane-replicated store data and byte enables; loads enable all lanes
  always_comb begin
    case (ex_size)
      2'b00: begin
        wdata_next = {4{ex_rs2[7:0]}};
        be_next    = 4'b0001 << ex_alu_result[1:0];
      end
      2'b01: begin
        wdata_next = {2{ex_rs2[15:0]}};
        be_next    = 4'b0011 << ex_alu_result[1:0];
      end
      default: begin
        wdata_next = ex_rs2;
        be_next    = 4'b1111;
      end
    endcase
    if (!ex_mem_write) be_next = 4'b1111;
  end

  // Load alignment and extension from the latched access attributes
  always_comb begin
    ld_shifted = dmem_rdata >> {r_off, 3'b000};
    case (r_size)
      2'b00:   ld_data = r_sign ? {24'h0, ld_shifted[7:0]}
                                : {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      2'b01:   ld_data = r_sign ? {16'h0, ld_shifted[15:0]}
                                : {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      default: ld_data = ld_shifted;
    endcase
  end

  // Stage FSM with registered bus and writeback outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      r_off        <= '0;
      r_size       <= '0;
      r_sign       <= 1'b0;
      r_reg_write  <= 1'b0;
      r_rd         <= '0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      dmem_be      <= '0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
      wb_data      <= '0;
      mem_err      <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      mem_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!is_mem) begin
              wb_valid     <= 1'b1;
              wb_rd        <= ex_rd;
              wb_reg_write <= ex_reg_write;
              wb_data      <= ex_alu_result;
            end else if (misaligned) begin
              wb_valid     <= 1'b1;
              mem_err      <= 1'b1;
              wb_rd        <= ex_rd;
              wb_reg_write <= 1'b0;
              wb_data      <= '0;
            end else begin
              state       <= WAIT;
              wait_cnt    <= '0;
              dmem_req    <= 1'b1;
              dmem_we     <= ex_mem_write;
              dmem_addr   <= {ex_alu_result[31:2], 2'b00};
              dmem_wdata  <= wdata_next;
              dmem_be     <= be_next;
              r_off       <= ex_alu_result[1:0];
              r_size      <= ex_size;
              r_sign      <= ex_sign;
              r_rd        <= ex_rd;
              r_reg_write <= ex_reg_write;
            end
          end
        end
        WAIT: begin
          // An ack on the final allowed cycle still completes the access
          if (dmem_ack) begin
            state    <= IDLE;
            dmem_req <= 1'b0;
            wb_valid <= 1'b1;
            wb_rd    <= r_rd;
            if (dmem_we) begin
              wb_reg_write <= 1'b0;
              wb_data      <= '0;
            end else begin
              wb_reg_write <= r_reg_write;
              wb_data      <= ld_data;
            end
          end else if (wait_cnt == LAST_WAIT) begin
            state        <= IDLE;
            dmem_req     <= 1'b0;
            wb_valid     <= 1'b1;
            mem_err      <= 1'b1;
            wb_rd        <= r_rd;
            wb_reg_write <= 1'b0;
            wb_data      <= '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// instruction streams compared against a transaction-level model.
module tb_mem_stage;

  logic        clk;
  logic        reset_n;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_flush;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_rs2;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [1:0]  ex_size;
  logic        ex_sign;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_data;
  logic        mem_err;

  mem_stage #(.TIMEOUT(255)) dut (
    .clk(clk), .reset_n(reset_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_flush(ex_flush),
    .ex_alu_result(ex_alu_result), .ex_rs2(ex_rs2),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_size(ex_size), .ex_sign(ex_sign), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .wb_data(wb_data), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic        rdk;
    logic [31:0] data;
    logic        rw;
    logic        err;
  } wb_t;

  wb_t q[$];
  wb_t last;
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  logic        exp_ready = 1'b1;
  logic        exp_req = 1'b0;
  logic        exp_we = 1'b0;
  logic [31:0] exp_addr = '0;
  logic [31:0] exp_wdata = '0;
  logic [3:0]  exp_be = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic misalign_m(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd3) || ((addr % nbytes(size)) != 0);
  endfunction

  function automatic logic [31:0] ld_model(input logic [31:0] rdata, input logic [1:0] off,
                                           input logic [1:0] size, input logic zext);
    int unsigned n;
    longint v;
    n = nbytes(size);
    v = longint'(rdata >> (8 * off));
    v = v % (longint'(1) << (8 * n));
    if (!zext && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic st_model(input logic [31:0] rs2, input logic [1:0] off, input logic [1:0] size,
                          output logic [31:0] wd, output logic [3:0] be);
    int unsigned n;
    logic [31:0] b;
    n = nbytes(size);
    wd = '0;
    be = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      b  = (rs2 >> (8 * (i % n))) & 32'hFF;
      wd = wd | (b << (8 * i));
      be[i] = (n == 4) || (i >= off && i < off + n);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    wb_t e;
    if (!reset_n) begin
      q.delete();
      last = '{cyc: 0, rd: 5'd0, rdk: 1'b1, data: 32'h0, rw: 1'b0, err: 1'b0};
      chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
      chk("rst_mem_err", {31'b0, mem_err}, 32'd0);
      chk("rst_wb_rw", {31'b0, wb_reg_write}, 32'd0);
      chk("rst_wb_rd", {27'b0, wb_rd}, 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_req", {31'b0, dmem_req}, 32'd0);
      chk("rst_we", {31'b0, dmem_we}, 32'd0);
      chk("rst_be", {28'b0, dmem_be}, 32'd0);
      chk("rst_addr", dmem_addr, 32'd0);
      chk("rst_wdata", dmem_wdata, 32'd0);
    end else begin
      while (q.size() > 0 && q[0].cyc < cyc) void'(q.pop_front());
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        chk("wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("wb_data", wb_data, e.data);
        chk("wb_reg_write", {31'b0, wb_reg_write}, {31'b0, e.rw});
        chk("mem_err", {31'b0, mem_err}, {31'b0, e.err});
        if (e.rdk) chk("wb_rd", {27'b0, wb_rd}, {27'b0, e.rd});
        last = e;
      end else begin
        chk("wb_valid_idle", {31'b0, wb_valid}, 32'd0);
        chk("mem_err_idle", {31'b0, mem_err}, 32'd0);
        chk("wb_data_hold", wb_data, last.data);
        chk("wb_rw_hold", {31'b0, wb_reg_write}, {31'b0, last.rw});
        if (last.rdk) chk("wb_rd_hold", {27'b0, wb_rd}, {27'b0, last.rd});
      end
      chk("ex_ready", {31'b0, ex_ready}, {31'b0, exp_ready});
      chk("dmem_req", {31'b0, dmem_req}, {31'b0, exp_req});
      if (exp_req) begin
        chk("dmem_addr", dmem_addr, exp_addr);
        chk("dmem_we", {31'b0, dmem_we}, {31'b0, exp_we});
        chk("dmem_be", {28'b0, dmem_be}, {28'b0, exp_be});
        if (exp_we) chk("dmem_wdata", dmem_wdata, exp_wdata);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] rd, input logic rdk, input logic [31:0] data,
                      input logic rw, input logic err);
    q.push_back('{cyc: cyc, rd: rd, rdk: rdk, data: data, rw: rw, err: err});
  endtask

  // lat = WAIT cycle carrying the ack (1..255); any other value never acks
  task automatic issue(input logic rd_op, input logic wr_op, input logic [1:0] size,
                       input logic zext, input logic [31:0] addr, input logic [31:0] rs2,
                       input logic [4:0] rd, input logic rw, input logic flush,
                       input int lat, input logic [31:0] rdata);
    logic [31:0] wd;
    logic [3:0]  be;
    ex_valid = 1'b1; ex_flush = flush;
    ex_mem_read = rd_op; ex_mem_write = wr_op; ex_size = size; ex_sign = zext;
    ex_alu_result = addr; ex_rs2 = rs2; ex_rd = rd; ex_reg_write = rw;
    dmem_ack = 1'($urandom % 2); dmem_rdata = $urandom;
    tick;
    ex_valid = 1'b0; ex_flush = 1'b0; dmem_ack = 1'b0;
    if (flush) return;
    if (!rd_op && !wr_op) begin
      push(rd, 1'b1, addr, rw, 1'b0);
      return;
    end
    if (misalign_m(size, addr)) begin
      push(rd, 1'b0, 32'h0, 1'b0, 1'b1);
      return;
    end
    st_model(rs2, addr[1:0], size, wd, be);
    exp_req = 1'b1; exp_ready = 1'b0; exp_we = wr_op;
    exp_addr = addr & ~32'd3; exp_wdata = wd; exp_be = wr_op ? be : 4'b1111;
    for (int k = 1; k <= 255; k++) begin
      dmem_ack = (k == lat);
      dmem_rdata = (k == lat) ? rdata : $urandom;
      ex_valid = 1'($urandom % 2); ex_flush = 1'($urandom % 2);
      tick;
      if (k == lat) begin
        if (wr_op) push(rd, 1'b0, 32'h0, 1'b0, 1'b0);
        else       push(rd, 1'b1, ld_model(rdata, addr[1:0], size, zext), rw, 1'b0);
        break;
      end
      if (k == 255) push(rd, 1'b0, 32'h0, 1'b0, 1'b1);
    end
    exp_req = 1'b0; exp_ready = 1'b1;
    ex_valid = 1'b0; ex_flush = 1'b0; dmem_ack = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wd;
    logic [3:0]  be;
    reset_n = 1'b0; ex_valid = 1'b0; ex_flush = 1'b0; ex_alu_result = '0; ex_rs2 = '0;
    ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_size = '0; ex_sign = 1'b0; ex_rd = '0;
    ex_reg_write = 1'b0; dmem_rdata = '0; dmem_ack = 1'b0;
    tick; tick;
    reset_n = 1'b1;

    // Hand-computed pins on the model
    chk("model_lb", ld_model(32'h80FF_0000, 2'd3, 2'd0, 1'b0), 32'hFFFF_FF80);
    chk("model_lbu", ld_model(32'h80FF_0000, 2'd2, 2'd0, 1'b1), 32'h0000_00FF);
    chk("model_lh", ld_model(32'h1234_8765, 2'd0, 2'd1, 1'b0), 32'hFFFF_8765);
    st_model(32'hDEAD_BEEF, 2'd2, 2'd1, wd, be);
    chk("model_sh_wd", wd, 32'hBEEF_BEEF);
    chk("model_sh_be", {28'b0, be}, 32'h0000_000C);
    st_model(32'hDEAD_BEEF, 2'd1, 2'd0, wd, be);
    chk("model_sb_wd", wd, 32'hEFEF_EFEF);
    chk("model_sb_be", {28'b0, be}, 32'h0000_0002);

    // Back-to-back ALU results, first acceptance right after reset
    issue(0, 0, 2'd2, 0, 32'h11, 0, 5'd1, 1, 0, 0, 0);
    chk("b2b_0x11", wb_data, 32'h11);
    issue(0, 0, 2'd2, 0, 32'h22, 0, 5'd2, 1, 0, 0, 0);
    chk("b2b_0x22", wb_data, 32'h22);
    issue(0, 0, 2'd2, 0, 32'h33, 0, 5'd3, 1, 0, 0, 0);
    chk("b2b_0x33", wb_data, 32'h33);
    chk("b2b_ready", {31'b0, ex_ready}, 32'd1);

    // Signed byte load with ack in the third WAIT cycle
    issue(1, 0, 2'd0, 0, 32'h1003, 0, 5'd7, 1, 0, 3, 32'h80FF_0000);
    chk("lb_data", wb_data, 32'hFFFF_FF80);
    chk("lb_rw", {31'b0, wb_reg_write}, 32'd1);

    // Halfword store
    issue(0, 1, 2'd1, 0, 32'h2002, 32'hDEAD_BEEF, 5'd8, 1, 0, 1, 0);
    chk("sh_rw", {31'b0, wb_reg_write}, 32'd0);

    // Misaligned word load
    issue(1, 0, 2'd2, 0, 32'h3001, 0, 5'd9, 1, 0, 1, 0);
    chk("mis_err", {31'b0, mem_err}, 32'd1);
    chk("mis_valid", {31'b0, wb_valid}, 32'd1);

    // Timeout, then ack on the last allowed cycle
    issue(1, 0, 2'd2, 0, 32'h4000, 0, 5'd10, 1, 0, 0, 0);
    chk("to_err", {31'b0, mem_err}, 32'd1);
    chk("to_data", wb_data, 32'd0);
    chk("to_ready", {31'b0, ex_ready}, 32'd1);
    issue(1, 0, 2'd2, 0, 32'h4004, 0, 5'd11, 1, 0, 255, 32'hCAFE_F00D);
    chk("ack255_err", {31'b0, mem_err}, 32'd0);
    chk("ack255_data", wb_data, 32'hCAFE_F00D);

    // Reset in the middle of an access
    ex_valid = 1'b1; ex_flush = 1'b0; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
    ex_size = 2'd2; ex_alu_result = 32'h5000; ex_rd = 5'd12; ex_reg_write = 1'b1;
    dmem_ack = 1'b0;
    tick;
    ex_valid = 1'b0;
    exp_req = 1'b1; exp_ready = 1'b0; exp_we = 1'b0; exp_addr = 32'h5000; exp_be = 4'hF;
    tick;
    #2 reset_n = 1'b0;
    exp_req = 1'b0; exp_ready = 1'b1;
    #1 chk("async_req_drop", {31'b0, dmem_req}, 32'd0);
    tick;
    reset_n = 1'b1;
    issue(0, 0, 2'd0, 0, 32'h77, 0, 5'd4, 1, 0, 0, 0);
    chk("post_rst_alu", wb_data, 32'h77);

    // Flushed instruction in IDLE
    issue(1, 0, 2'd2, 0, 32'h6000, 0, 5'd5, 1, 1, 1, 0);
    tick;

    // Randomized stream
    for (int n = 0; n < 250; n++) begin
      int unsigned kind;
      int lat;
      logic fl;
      kind = $urandom % 10;
      fl = ($urandom % 8) == 0;
      lat = (($urandom % 40) == 0) ? 0 : int'($urandom_range(1, 6));
      case (kind)
        0, 1, 2: issue(0, 0, 2'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom),
                       1'($urandom), fl, 0, 0);
        3, 4, 5: issue(1, 0, 2'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom),
                       1'($urandom), fl, lat, $urandom);
        6, 7, 8: issue(0, 1, 2'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom),
                       1'($urandom), fl, lat, $urandom);
        default: begin
          ex_valid = 1'b0; dmem_ack = 1'($urandom % 2); dmem_rdata = $urandom;
          tick;
          dmem_ack = 1'b0;
        end
      endcase
    end
    tick; tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have the parameter TIMEOUT, default 255, giving the maximum number of WAIT cycles before a bus error is declared.
REQ-002 The block SHALL have these ports, listed as name, direction, width and meaning:
- clk  in  1  the single clock; all state updates on its rising edge.
- reset_n  in  1  reset; asynchronous, active-low.
- ex_valid  in  1  an instruction is presented by the EX stage.
- ex_ready  out  1  the stage accepts the presented instruction this cycle.
- ex_flush  in  1  discard the instruction presented this cycle.
- ex_alu_result  in  32  the effective address, or the result for non-memory instructions.
- ex_rs2  in  32  the store data.
- ex_mem_read  in  1  the instruction is a load.
- ex_mem_write  in  1  the instruction is a store.
- ex_size  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- ex_sign  in  1  1 = zero-extend loads (funct3[2]).
- ex_rd  in  5  the destination register.
- ex_reg_write  in  1  the instruction writes the register file.
- dmem_req  out  1  data-bus request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_rdata  in  32  read data, valid when dmem_ack is 1.
- dmem_ack  in  1  the request completes this cycle.
- wb_valid  out  1  the writeback bundle is valid for one cycle.
- wb_rd  out  5  the writeback destination.
- wb_reg_write  out  1  the writeback write enable.
- wb_data  out  32  the writeback value; also the forwarding source.
- mem_err  out  1  a one-cycle pulse, coincident with wb_valid, on misalignment or timeout.

Function
REQ-003 The FSM SHALL have two states: IDLE and WAIT.
REQ-004 ex_ready SHALL be 1 in IDLE and 0 in WAIT.
REQ-005 An instruction SHALL be accepted when ex_valid && ex_ready && !ex_flush.
REQ-006 When ex_flush is 1 in IDLE, the presented instruction SHALL be dropped and no wb_valid SHALL follow.
REQ-007 ex_flush SHALL be ignored while in WAIT, because an issued memory operation always completes.
REQ-008 An accepted non-memory instruction SHALL produce, on the next cycle, wb_valid=1, wb_data=ex_alu_result, wb_rd=ex_rd and wb_reg_write=ex_reg_write; the FSM stays in IDLE, giving throughput of 1 per cycle.
REQ-009 An access SHALL be misaligned when it is a half access with addr[0]=1, a word access with addr[1:0]!=0, or ex_size=11.
REQ-010 A misaligned access SHALL issue no bus request; the next cycle SHALL have wb_valid=1, mem_err=1, wb_reg_write=0 and wb_data=0.
REQ-011 An accepted aligned load or store SHALL move the FSM to WAIT and latch the address, size, sign, rd and reg_write.
REQ-012 In WAIT, dmem_req SHALL be 1 and dmem_addr, dmem_we, dmem_be and dmem_wdata SHALL be held stable until the ack cycle.
REQ-013 Store data and byte enables SHALL be formed as follows:
- SB: wdata={4{rs2[7:0]}}, be=4'b0001<<addr[1:0].
- SH: wdata={2{rs2[15:0]}}, be=4'b0011<<addr[1:0].
- SW: wdata=rs2, be=4'b1111.
REQ-014 For loads, dmem_be SHALL be 4'b1111.
REQ-015 On a cycle with dmem_ack=1 in WAIT:
- the FSM SHALL return to IDLE;
- the next cycle SHALL have wb_valid=1;
- for a load, wb_data SHALL be (dmem_rdata >> 8*addr[1:0]) truncated to the access size, then sign-extended (ex_sign=0) or zero-extended (ex_sign=1);
- for a store, wb_reg_write SHALL be 0 and wb_data SHALL be 0.
REQ-016 Minimum memory latency SHALL be 2 cycles from acceptance to wb_valid, when the ack arrives in the first WAIT cycle.
REQ-017 An 8-bit wait counter SHALL clear on entry to WAIT and increment for each WAIT cycle without an ack.
REQ-018 When the wait counter reaches TIMEOUT with no ack:
- dmem_req SHALL drop and the FSM SHALL return to IDLE;
- the next cycle SHALL have wb_valid=1, mem_err=1, wb_reg_write=0 and wb_data=0.
REQ-019 An ack arriving in the same cycle the counter reaches TIMEOUT SHALL win: the access completes normally.
REQ-020 dmem_ack SHALL be ignored while in IDLE.
REQ-021 wb_valid and mem_err SHALL be single-cycle pulses; wb_rd, wb_data and wb_reg_write SHALL hold their values between pulses.

Reset
REQ-022 While reset_n=0, the block SHALL have:
- state=IDLE and wait counter=0;
- dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0;
- wb_valid=0, wb_reg_write=0, wb_rd=0, wb_data=0, mem_err=0.
REQ-023 Reset asserted in WAIT SHALL abandon the access immediately, with dmem_req=0 asynchronously and no wb_valid afterwards.
REQ-024 After reset_n rises, the first acceptance SHALL be possible on the first rising clock edge.

Verification
REQ-025 Back-to-back ALU results: ALU results 0x11, 0x22, 0x33 with rd=1,2,3 on consecutive cycles -> wb_valid on 3 consecutive cycles with wb_data 0x11, 0x22, 0x33 and ex_ready held at 1.
REQ-026 Signed byte load: LB at addr 0x1003, ack after 3 cycles with rdata 0x80FF_0000 -> ex_ready=0 for 3 cycles; wb_data=0xFFFF_FF80, wb_reg_write=1.
REQ-027 Halfword store: SH at addr 0x2002, rs2=0xDEAD_BEEF -> dmem_addr=0x2000, dmem_be=1100, dmem_wdata=0xBEEF_BEEF; on completion wb_reg_write=0.
REQ-028 Misaligned word load: LW at addr 0x3001 -> dmem_req stays 0; the next cycle has mem_err=1, wb_valid=1, wb_reg_write=0.
REQ-029 Timeout: LW with no ack -> after 255 WAIT cycles, mem_err=1, wb_data=0 and ex_ready returns to 1; repeating the test with the ack in cycle 255 completes the load normally.
REQ-030 Reset mid-access: reset_n=0 during WAIT -> dmem_req=0 without waiting for clk, and no wb_valid follows; a flush presented in IDLE yields no wb_valid.
